// File: rtl/vector_sync_sequencer.sv
// vector_sync_sequencer: turns vector records into tester_sync pulses, stalling so the generator FIFO never wraps
module vector_sync_sequencer #(
  parameter int DELAY_W = 32,
  parameter int INT_W = 32,
  parameter int PERIOD_W = 16,
  parameter int REPEAT_W = 16,
  parameter int MAX_OUTSTANDING = 31
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                vec_valid,
  output logic                vec_ready,
  input  logic [PERIOD_W-1:0] vec_period,
  input  logic [REPEAT_W-1:0] vec_repeat,
  input  logic [DELAY_W-1:0]  vec_delay,
  input  logic                vec_last,
  input  logic                channel_sync,
  output logic                tester_sync,
  output logic [DELAY_W-1:0]  delay,
  output logic [INT_W-1:0]    cur_vector_number,
  output logic [INT_W-1:0]    cur_cycle_number,
  output logic                busy,
  output logic                done,
  output logic                overflow_err
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, HOLD, DRAIN, DONE} state_t;
  state_t state;
  logic [OW-1:0] outstanding;
  logic [PERIOD_W-1:0] per, per_cnt;
  logic [REPEAT_W-1:0] rpt_left;
  logic last, sync_seen, cs_q, known, retire, issue;
  assign known = (channel_sync === 1'b0) || (channel_sync === 1'b1);
  assign retire = known && (!sync_seen || channel_sync != cs_q);
  assign issue = state == ISSUE && !stop && outstanding < OW'(MAX_OUTSTANDING);
  assign tester_sync = issue;
  assign vec_ready = state == FETCH && !stop;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      outstanding <= '0;
      sync_seen <= 1'b0;
      cs_q <= 1'b0;
      overflow_err <= 1'b0;
      delay <= '0;
      cur_vector_number <= '0;
      cur_cycle_number <= '0;
      per <= '0;
      per_cnt <= '0;
      rpt_left <= '0;
      last <= 1'b0;
    end else begin
      cs_q <= known ? channel_sync : cs_q;
      sync_seen <= sync_seen || known;
      outstanding <= (issue == retire) ? outstanding :
                     issue ? outstanding + 1'b1 :
                     (outstanding == '0) ? outstanding : outstanding - 1'b1;
      overflow_err <= overflow_err || (retire && !issue && outstanding == '0);
      if (stop) state <= IDLE;
      else case (state)
        IDLE: if (start) begin
          state <= FETCH;
          cur_vector_number <= '0;
          cur_cycle_number <= '0;
        end
        FETCH: if (vec_valid) begin
          rpt_left <= (vec_repeat == '0) ? REPEAT_W'(1) : vec_repeat;
          per <= (vec_period < PERIOD_W'(2)) ? PERIOD_W'(2) : vec_period;
          delay <= vec_delay;
          last <= vec_last;
          state <= ISSUE;
        end
        ISSUE: if (issue) begin
          per_cnt <= per - 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          per_cnt <= per_cnt - 1'b1;
          if (per_cnt == PERIOD_W'(1)) begin
            cur_cycle_number <= cur_cycle_number + 1'b1;
            if (rpt_left > REPEAT_W'(1)) begin
              rpt_left <= rpt_left - 1'b1;
              state <= ISSUE;
            end else begin
              cur_vector_number <= cur_vector_number + 1'b1;
              state <= last ? DRAIN : FETCH;
            end
          end
        end
        DRAIN: if (outstanding == '0) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_sync_sequencer.sv
// tb_vector_sync_sequencer: random and directed records checked against a timeline model of the sequencer
module tb_vector_sync_sequencer;
  localparam int DW = 32, IW = 32, PW = 16, RW = 16, MAXO = 31;
  typedef struct { logic [PW-1:0] per; logic [RW-1:0] rpt; logic [DW-1:0] dly; logic last; } rec_t;
  typedef enum int {M_IDLE, M_REC, M_PULSE, M_DRAIN, M_DONE} phase_t;
  typedef int intq_t[$];
  logic clk = 0, reset_n = 0, start = 0, stop = 0, vec_valid = 0, vec_last = 0, channel_sync = 0;
  logic [PW-1:0] vec_period = '0;
  logic [RW-1:0] vec_repeat = '0;
  logic [DW-1:0] vec_delay = '0;
  logic vec_ready, tester_sync, busy, done, overflow_err;
  logic [DW-1:0] delay;
  logic [IW-1:0] cur_vector_number, cur_cycle_number;
  int errors = 0, checks = 0;
  rec_t recs[$];
  intq_t pt, pv, pc;
  phase_t ph = M_IDLE;
  logic [IW-1:0] m_vec = '0, m_cyc = '0;
  logic [DW-1:0] m_dly = '0;
  int m_per = 0, m_rpt = 0, m_out = 0, end_cyc = 0, cyc_n = 0, owed = 0;
  int valid_pct = 100, retire_pct = 50, dut_done = 0;
  logic m_last = 0, pulsed = 0, m_ovf = 0, seen = 0, force_one = 0;
  always #5 clk = ~clk;
  vector_sync_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_period(vec_period),
    .vec_repeat(vec_repeat), .vec_delay(vec_delay), .vec_last(vec_last),
    .channel_sync(channel_sync), .tester_sync(tester_sync), .delay(delay),
    .cur_vector_number(cur_vector_number), .cur_cycle_number(cur_cycle_number),
    .busy(busy), .done(done), .overflow_err(overflow_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask
  task automatic check_seq(input string tag, input intq_t got, input intq_t exp);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
  endtask
  function automatic intq_t gaps();
    intq_t g;
    for (int i = 1; i < pt.size(); i++) g.push_back(pt[i] - pt[i-1]);
    return g;
  endfunction
  task automatic add(input int p, input int n, input int d, input logic l);
    recs.push_back(rec_t'{PW'(p), RW'(n), DW'(d), l});
  endtask
  task automatic clear_log();
    pt.delete();
    pv.delete();
    pc.delete();
  endtask
  task automatic do_reset();
    reset_n = 0;
    start = 1'($urandom);
    stop = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rst_tester_sync", tester_sync, 0);
    check("rst_vec_ready", vec_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_delay", delay, 0);
    check("rst_vector", cur_vector_number, 0);
    check("rst_cycle", cur_cycle_number, 0);
    check("rst_overflow", overflow_err, 0);
    reset_n = 1;
    start = 0;
    stop = 0;
    channel_sync = 1'($urandom);
    ph = M_IDLE;
    m_vec = '0;
    m_cyc = '0;
    m_dly = '0;
    m_out = 0;
    m_ovf = 0;
    seen = 0;
    owed = 0;
    pulsed = 0;
    force_one = 0;
    recs.delete();
  endtask
  task automatic step(input logic st, input logic sp);
    logic retire, exp_sync, exp_ready;
    int old;
    rec_t r;
    start = st;
    stop = sp;
    vec_valid = recs.size() > 0 && $urandom_range(99) < valid_pct;
    if (recs.size() > 0) r = recs[0];
    else r = rec_t'{PW'($urandom), RW'($urandom), DW'($urandom), 1'($urandom)};
    vec_period = r.per;
    vec_repeat = r.rpt;
    vec_delay = r.dly;
    vec_last = r.last;
    retire = 0;
    if (!seen) begin
      seen = 1;
      retire = 1;
    end else if (owed > 0 && (force_one || $urandom_range(99) < retire_pct)) begin
      channel_sync = ~channel_sync;
      owed--;
      retire = 1;
      force_one = 0;
    end
    @(negedge clk);
    exp_sync = ph == M_PULSE && !pulsed && m_out < MAXO && !sp;
    exp_ready = ph == M_REC && !sp;
    check("tester_sync", tester_sync, exp_sync);
    check("vec_ready", vec_ready, exp_ready);
    check("busy", busy, ph != M_IDLE);
    check("done", done, ph == M_DONE);
    check("delay", delay, m_dly);
    check("vector", cur_vector_number, m_vec);
    check("cycle", cur_cycle_number, m_cyc);
    check("overflow", overflow_err, m_ovf);
    if (tester_sync) begin
      pt.push_back(cyc_n);
      pv.push_back(int'(cur_vector_number));
      pc.push_back(int'(cur_cycle_number));
    end
    if (done) dut_done++;
    if (exp_sync) owed++;
    old = m_out;
    if (exp_sync && !retire) m_out++;
    else if (retire && !exp_sync) begin
      if (m_out == 0) m_ovf = 1;
      else m_out--;
    end
    if (sp) ph = M_IDLE;
    else case (ph)
      M_IDLE: if (st) begin
        ph = M_REC;
        m_vec = '0;
        m_cyc = '0;
      end
      M_REC: if (exp_ready && vec_valid) begin
        r = recs.pop_front();
        m_per = (r.per < 2) ? 2 : int'(r.per);
        m_rpt = (r.rpt == 0) ? 1 : int'(r.rpt);
        m_dly = r.dly;
        m_last = r.last;
        pulsed = 0;
        ph = M_PULSE;
      end
      M_PULSE: if (exp_sync) begin
        pulsed = 1;
        end_cyc = cyc_n + m_per - 1;
      end else if (pulsed && cyc_n == end_cyc) begin
        m_cyc++;
        m_rpt--;
        pulsed = 0;
        if (m_rpt == 0) begin
          m_vec++;
          ph = m_last ? M_DRAIN : M_REC;
        end
      end
      M_DRAIN: if (old == 0) ph = M_DONE;
      M_DONE: ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
    cyc_n++;
    @(posedge clk);
    #1;
  endtask
  task automatic run_to_idle(input int budget);
    for (int k = 0; k < budget && ph != M_IDLE; k++) step(0, 0);
    check("idle_reached", busy, 0);
  endtask
  task automatic run(input int budget);
    int d0;
    d0 = dut_done;
    step(1, 0);
    run_to_idle(budget);
    check("done_pulse", dut_done - d0, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, d;
    do_reset();
    step(0, 0);
    check("ovf_first_known", overflow_err, 1);
    clear_log();
    add(4, 3, 7, 1);
    run(500);
    check_seq("t1_gap", gaps(), '{4, 4});
    check_seq("t1_cyc", pc, '{0, 1, 2});
    check_seq("t1_vec", pv, '{0, 0, 0});
    clear_log();
    add(2, 1, 11, 0);
    add(5, 2, 12, 1);
    run(500);
    check_seq("t2_gap", gaps(), '{3, 5});
    check_seq("t2_vec", pv, '{0, 1, 1});
    check_seq("t2_cyc", pc, '{0, 1, 2});
    clear_log();
    add(2, 40, 3, 1);
    retire_pct = 0;
    step(1, 0);
    repeat (120) step(0, 0);
    check("t3_stall_pulses", pt.size(), 31);
    force_one = 1;
    repeat (10) step(0, 0);
    check("t3_one_more", pt.size(), 32);
    retire_pct = 60;
    run_to_idle(2000);
    check("t3_total", pt.size(), 40);
    clear_log();
    add(0, 0, 5, 0);
    add(3, 1, 6, 1);
    run(500);
    check_seq("t4_gap", gaps(), '{3});
    check_seq("t4_cyc", pc, '{0, 1});
    clear_log();
    add(3, 10, 9, 1);
    step(1, 0);
    for (int k = 0; k < 200 && !(m_cyc == 5 && ph == M_PULSE && pulsed); k++) step(0, 0);
    step(0, 1);
    n = pt.size();
    d = dut_done;
    repeat (10) step(0, 0);
    check("t5_no_pulse", pt.size(), n);
    check("t5_no_done", dut_done, d);
    check("t5_cyc_hold", cur_cycle_number, 5);
    check("t5_idle", busy, 0);
    add(2, 1, 1, 1);
    step(1, 0);
    check("t5_restart_cyc", cur_cycle_number, 0);
    check("t5_restart_vec", cur_vector_number, 0);
    run_to_idle(500);
    add(3, 5, 2, 1);
    step(1, 0);
    repeat (7) step(0, 0);
    do_reset();
    step(0, 0);
    check("t6_ovf_after_reset", overflow_err, 1);
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(4, 1);
      for (int i = 0; i < n; i++) add($urandom_range(6), $urandom_range(5), $urandom, i == n - 1);
      valid_pct = $urandom_range(100, 40);
      retire_pct = $urandom_range(90, 20);
      step(1, 0);
      for (int k = 0; k < 3000 && ph != M_IDLE; k++) step($urandom_range(99) < 3, $urandom_range(299) == 0);
      check("rand_idle", busy, 0);
      recs.delete();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
